regfile_access_arbiter: RTL and testbench

- Shares the single-port register file between two requesters: requester 0 is the system controller command path; requester 1 is a secondary master (config loader or debug port).
- Round-robin arbitration with one outstanding transaction at a time.
- Drives the register file Address/WrEn/RdEn/WrData pins and routes RdData back to the granted requester.
- Times out reads whose RdData_Valid never arrives.

---
 rtl/regfile_arb_pkg.sv | 19 +
 rtl/rr_arb2.sv | 23 ++
 rtl/regfile_access_arbiter.sv | 161 ++++++++++++++++
 tb/tb_regfile_access_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_arb_pkg.sv
// Shared definitions for the register file access arbiter: FSM encoding,
// requester identifiers and timeout defaults.
package regfile_arb_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StWrite    = 2'd1,
        StReadWait = 2'd2,
        StDone     = 2'd3
    } arb_state_e;

    localparam logic REQ_ID_SYS = 1'b0;
    localparam logic REQ_ID_AUX = 1'b1;

    localparam int unsigned RD_TIMEOUT_DEFAULT = 15;
    // Wide enough for the largest legal RD_TIMEOUT of 255.
    localparam int unsigned TIMEOUT_CNT_W = 8;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker: a lone requester wins outright,
// a tie goes to whichever requester was not granted last.
module rr_arb2
    import regfile_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_gnt_i,
    output logic       win_id_o,
    output logic       any_req_o
);

    always_comb begin
        any_req_o = |req_i;
        win_id_o  = REQ_ID_SYS;
        unique case (req_i)
            2'b01:   win_id_o = REQ_ID_SYS;
            2'b10:   win_id_o = REQ_ID_AUX;
            2'b11:   win_id_o = ~last_gnt_i;
            default: win_id_o = REQ_ID_SYS;
        endcase
    end

endmodule

// File: rtl/regfile_access_arbiter.sv
// Shares a single-port register file between the system command path and a
// secondary master; one outstanding transaction, timed-out reads complete with RD_ERR.
module regfile_access_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned REGFILE_ADD = 4,
    parameter int unsigned RD_TIMEOUT  = RD_TIMEOUT_DEFAULT
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   REQ0,
    input  logic                   WR0,
    input  logic [REGFILE_ADD-1:0] ADDR0,
    input  logic [DATA_WIDTH-1:0]  WDATA0,
    output logic                   GNT0,
    output logic [DATA_WIDTH-1:0]  RDATA0,
    output logic                   RVALID0,
    input  logic                   REQ1,
    input  logic                   WR1,
    input  logic [REGFILE_ADD-1:0] ADDR1,
    input  logic [DATA_WIDTH-1:0]  WDATA1,
    output logic                   GNT1,
    output logic [DATA_WIDTH-1:0]  RDATA1,
    output logic                   RVALID1,
    output logic                   RD_ERR,
    output logic [REGFILE_ADD-1:0] Address,
    output logic                   WrEn,
    output logic                   RdEn,
    output logic [DATA_WIDTH-1:0]  WrData,
    input  logic [DATA_WIDTH-1:0]  RdData,
    input  logic                   RdData_Valid
);

    localparam logic [TIMEOUT_CNT_W-1:0] CntLast = TIMEOUT_CNT_W'(RD_TIMEOUT - 1);

    arb_state_e                 state_q;
    logic                       last_gnt_q;
    logic                       cur_id_q;
    logic [TIMEOUT_CNT_W-1:0]   cnt_q;
    logic [1:0]                 gnt_q;
    logic [1:0]                 rvalid_q;
    logic                       rd_err_q;
    logic                       wr_en_q;
    logic                       rd_en_q;
    logic [REGFILE_ADD-1:0]     addr_q;
    logic [DATA_WIDTH-1:0]      wdata_q;
    logic [DATA_WIDTH-1:0]      rdata0_q;
    logic [DATA_WIDTH-1:0]      rdata1_q;

    logic                       win_id;
    logic                       any_req;
    logic                       sel_wr;
    logic [REGFILE_ADD-1:0]     sel_addr;
    logic [DATA_WIDTH-1:0]      sel_wdata;
    logic [DATA_WIDTH-1:0]      rd_result;
    logic                       rd_complete;

    rr_arb2 u_rr_arb2 (
        .req_i      ({REQ1, REQ0}),
        .last_gnt_i (last_gnt_q),
        .win_id_o   (win_id),
        .any_req_o  (any_req)
    );

    always_comb begin
        sel_wr    = WR0;
        sel_addr  = ADDR0;
        sel_wdata = WDATA0;
        if (win_id == REQ_ID_AUX) begin
            sel_wr    = WR1;
            sel_addr  = ADDR1;
            sel_wdata = WDATA1;
        end
    end

    // A timed-out read returns zero data rather than whatever is on the bus.
    always_comb begin
        rd_complete = RdData_Valid || (cnt_q == CntLast);
        rd_result   = RdData_Valid ? RdData : '0;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= StIdle;
            last_gnt_q <= REQ_ID_AUX;
            cur_id_q   <= REQ_ID_SYS;
            cnt_q      <= '0;
            gnt_q      <= '0;
            rvalid_q   <= '0;
            rd_err_q   <= 1'b0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            gnt_q    <= '0;
            rvalid_q <= '0;
            rd_err_q <= 1'b0;
            wr_en_q  <= 1'b0;
            rd_en_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        gnt_q[win_id] <= 1'b1;
                        last_gnt_q    <= win_id;
                        cur_id_q      <= win_id;
                        addr_q        <= sel_addr;
                        wdata_q       <= sel_wdata;
                        if (sel_wr) begin
                            wr_en_q <= 1'b1;
                            state_q <= StWrite;
                        end else begin
                            rd_en_q <= 1'b1;
                            state_q <= StReadWait;
                        end
                    end
                end
                StWrite: begin
                    state_q <= StIdle;
                end
                StReadWait: begin
                    if (rd_complete) begin
                        rvalid_q[cur_id_q] <= 1'b1;
                        rd_err_q           <= ~RdData_Valid;
                        if (cur_id_q == REQ_ID_AUX) begin
                            rdata1_q <= rd_result;
                        end else begin
                            rdata0_q <= rd_result;
                        end
                        cnt_q   <= '0;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + TIMEOUT_CNT_W'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign GNT0    = gnt_q[0];
    assign GNT1    = gnt_q[1];
    assign RVALID0 = rvalid_q[0];
    assign RVALID1 = rvalid_q[1];
    assign RD_ERR  = rd_err_q;
    assign RDATA0  = rdata0_q;
    assign RDATA1  = rdata1_q;
    assign Address = addr_q;
    assign WrData  = wdata_q;
    assign WrEn    = wr_en_q;
    assign RdEn    = rd_en_q;

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Self-checking bench for regfile_access_arbiter: transaction-level model of the
// arbitration and completion timing plus a behavioural register file with variable latency.
module tb_regfile_access_arbiter;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int TO = 15;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          REQ0 = 1'b0, WR0 = 1'b0, REQ1 = 1'b0, WR1 = 1'b0;
    logic [AW-1:0] ADDR0 = '0, ADDR1 = '0;
    logic [DW-1:0] WDATA0 = '0, WDATA1 = '0;
    logic          GNT0, GNT1, RVALID0, RVALID1, RD_ERR, WrEn, RdEn;
    logic [DW-1:0] RDATA0, RDATA1, WrData;
    logic [AW-1:0] Address;
    logic [DW-1:0] RdData = '0;
    logic          RdData_Valid = 1'b0;

    int checks = 0;
    int errors = 0;

    // Reference state: expected memory contents, expected RDATA per requester,
    // last granted requester.
    logic [DW-1:0] exp_mem [16];
    logic [DW-1:0] exp_rdata [2];
    bit            m_last;

    // Behavioural register file driven from the DUT pins.
    logic [DW-1:0] rf_mem [16];
    int            rf_lat = 1;
    int            rf_pend = 0;
    logic [DW-1:0] rf_data = '0;

    // Pending transaction fields for each requester.
    logic          t_wr [2];
    logic [AW-1:0] t_addr [2];
    logic [DW-1:0] t_data [2];

    always #5 CLK = ~CLK;

    regfile_access_arbiter #(
        .DATA_WIDTH  (DW),
        .REGFILE_ADD (AW),
        .RD_TIMEOUT  (TO)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .REQ0         (REQ0),
        .WR0          (WR0),
        .ADDR0        (ADDR0),
        .WDATA0       (WDATA0),
        .GNT0         (GNT0),
        .RDATA0       (RDATA0),
        .RVALID0      (RVALID0),
        .REQ1         (REQ1),
        .WR1          (WR1),
        .ADDR1        (ADDR1),
        .WDATA1       (WDATA1),
        .GNT1         (GNT1),
        .RDATA1       (RDATA1),
        .RVALID1      (RVALID1),
        .RD_ERR       (RD_ERR),
        .Address      (Address),
        .WrEn         (WrEn),
        .RdEn         (RdEn),
        .WrData       (WrData),
        .RdData       (RdData),
        .RdData_Valid (RdData_Valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        #1;
        chk("gnt_exclusive", 32'(GNT0 & GNT1), 32'(0));
        chk("strobe_exclusive", 32'(WrEn & RdEn), 32'(0));
        if (WrEn) rf_mem[Address] = WrData;
        RdData_Valid = 1'b0;
        if (rf_pend > 0) begin
            rf_pend--;
            if (rf_pend == 0) begin
                RdData_Valid = 1'b1;
                RdData       = rf_data;
            end
        end
        if (RdEn && rf_lat > 0) begin
            rf_pend = rf_lat;
            rf_data = rf_mem[Address];
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl"}, 32'({GNT0, GNT1, RVALID0, RVALID1, RD_ERR, WrEn, RdEn}), 32'(0));
        chk({tag, "_data"}, 32'({RDATA0, RDATA1, WrData, Address}), 32'(0));
    endtask

    task automatic do_reset();
        RST  = 1'b0;
        REQ0 = 1'b0;
        REQ1 = 1'b0;
        rf_pend = 0;
        RdData_Valid = 1'b0;
        #1;
        chk_all_zero("reset");
        cycle();
        cycle();
        chk_all_zero("reset_held");
        RST = 1'b1;
        m_last = 1'b1;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
    endtask

    task automatic rand_fields(input int id);
        t_wr[id]   = 1'($urandom_range(0, 1));
        t_addr[id] = AW'($urandom_range(0, 15));
        t_data[id] = DW'($urandom);
    endtask

    // Serve every requester in mask to completion, predicting order and timing.
    task automatic serve(input logic [1:0] mask, input int lat);
        logic [1:0] pend;
        bit         win;
        bit         ok_rd;
        int         n;
        int         n_exp;
        pend   = mask;
        rf_lat = lat;
        ok_rd  = (lat >= 1) && (lat < TO);
        REQ0 = mask[0]; WR0 = t_wr[0]; ADDR0 = t_addr[0]; WDATA0 = t_data[0];
        REQ1 = mask[1]; WR1 = t_wr[1]; ADDR1 = t_addr[1]; WDATA1 = t_data[1];
        while (pend != 2'b00) begin
            win = (pend == 2'b11) ? !m_last : pend[1];
            cycle();
            chk("gnt0", 32'(GNT0), 32'(win == 1'b0));
            chk("gnt1", 32'(GNT1), 32'(win == 1'b1));
            chk("address", 32'(Address), 32'(t_addr[win]));
            chk("wrdata", 32'(WrData), 32'(t_data[win]));
            chk("wren", 32'(WrEn), 32'(t_wr[win]));
            chk("rden", 32'(RdEn), 32'(!t_wr[win]));
            m_last    = win;
            pend[win] = 1'b0;
            if (win) REQ1 = 1'b0;
            else REQ0 = 1'b0;
            if (t_wr[win]) begin
                exp_mem[t_addr[win]] = t_data[win];
                cycle();
                chk("wr_drop", 32'({GNT0, GNT1, WrEn}), 32'(0));
            end else begin
                n_exp = ok_rd ? lat + 1 : TO;
                n = 0;
                do begin
                    cycle();
                    n++;
                end while (!(RVALID0 || RVALID1) && n < 3 * TO);
                chk("rvalid_latency", 32'(n), 32'(n_exp));
                chk("rvalid_target", 32'({RVALID1, RVALID0}), win ? 32'(2) : 32'(1));
                exp_rdata[win] = ok_rd ? exp_mem[t_addr[win]] : '0;
                chk("rd_err", 32'(RD_ERR), 32'(!ok_rd));
                chk("rdata0", 32'(RDATA0), 32'(exp_rdata[0]));
                chk("rdata1", 32'(RDATA1), 32'(exp_rdata[1]));
                cycle();
                chk("rvalid_drop", 32'({RVALID0, RVALID1, RD_ERR}), 32'(0));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   e0;
        bit   e1;
        bit   w;
        int   r;
        int   lat;
        for (int i = 0; i < 16; i++) begin
            exp_mem[i] = DW'($urandom);
            rf_mem[i]  = exp_mem[i];
        end
        do_reset();

        // Directed write from requester 0.
        t_wr[0] = 1'b1; t_addr[0] = 4'h3; t_data[0] = 8'hA5;
        serve(2'b01, 1);

        // Requester 1 reads it back with latency 1.
        t_wr[1] = 1'b0; t_addr[1] = 4'h3; t_data[1] = 8'h00;
        serve(2'b10, 1);
        chk("rdata1_a5", 32'(RDATA1), 32'(8'hA5));

        // Both held continuously: grants alternate 0,1,0,1 every two cycles.
        do_reset();
        t_wr[0] = 1'b1; t_addr[0] = 4'h5; t_data[0] = 8'h11;
        t_wr[1] = 1'b1; t_addr[1] = 4'h6; t_data[1] = 8'h22;
        REQ0 = 1'b1; WR0 = 1'b1; ADDR0 = t_addr[0]; WDATA0 = t_data[0];
        REQ1 = 1'b1; WR1 = 1'b1; ADDR1 = t_addr[1]; WDATA1 = t_data[1];
        for (int i = 0; i < 8; i++) begin
            cycle();
            e0 = (i % 2 == 0) && ((i / 2) % 2 == 0);
            e1 = (i % 2 == 0) && ((i / 2) % 2 == 1);
            chk("alt_gnt0", 32'(GNT0), 32'(e0));
            chk("alt_gnt1", 32'(GNT1), 32'(e1));
            chk("alt_wren", 32'(WrEn), 32'(e0 | e1));
        end
        REQ0 = 1'b0;
        REQ1 = 1'b0;
        exp_mem[4'h5] = 8'h11;
        exp_mem[4'h6] = 8'h22;
        m_last = 1'b1;
        cycle();

        // Timeout read followed by a normal write from the other side.
        t_wr[0] = 1'b0; t_addr[0] = 4'h5;
        serve(2'b01, 0);
        t_wr[1] = 1'b1; t_addr[1] = 4'h9; t_data[1] = 8'h3C;
        serve(2'b10, 1);

        // Latency boundaries: last cycle before timeout, and one cycle too late.
        t_wr[1] = 1'b0; t_addr[1] = 4'h9;
        serve(2'b10, TO - 1);
        t_wr[0] = 1'b0; t_addr[0] = 4'h6;
        serve(2'b01, TO);

        // Stray RdData_Valid while idle.
        RdData = 8'h5A;
        RdData_Valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("idle_rvalid", 32'({RVALID0, RVALID1, RD_ERR}), 32'(0));
            chk("idle_rdata0", 32'(RDATA0), 32'(exp_rdata[0]));
            chk("idle_rdata1", 32'(RDATA1), 32'(exp_rdata[1]));
        end

        // Reset during READ_WAIT; the late valid must not produce a completion.
        t_wr[1] = 1'b0; t_addr[1] = 4'h3;
        rf_lat = 3;
        REQ1 = 1'b1; WR1 = 1'b0; ADDR1 = t_addr[1];
        cycle();
        chk("mid_gnt1", 32'({GNT1, RdEn}), 32'(3));
        REQ1 = 1'b0;
        cycle();
        RST = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        cycle();
        RST = 1'b1;
        m_last = 1'b1;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("post_reset_quiet", 32'({GNT0, GNT1, RVALID0, RVALID1, RD_ERR}), 32'(0));
        end
        t_wr[0] = 1'b1; t_addr[0] = 4'hC; t_data[0] = 8'h77;
        t_wr[1] = 1'b1; t_addr[1] = 4'hD; t_data[1] = 8'h88;
        serve(2'b11, 1);

        // Randomized traffic.
        for (int k = 0; k < 40; k++) begin
            rand_fields(0);
            rand_fields(1);
            r = $urandom_range(0, 9);
            if (r == 0) lat = 0;
            else if (r == 1) lat = TO;
            else lat = $urandom_range(1, TO - 1);
            serve(2'($urandom_range(1, 3)), lat);
            w = 1'($urandom_range(0, 1));
            if (w) cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
